// File: rtl/alu_drv_pkg.sv
// Shared types for the breadboard ALU op driver: opcode and FSM state
// encodings plus default widths.
package alu_drv_pkg;

   localparam int DW_DEF  = 32;
   localparam int OPW_DEF = 4;

   typedef enum logic [3:0] {
      OP_HOLD = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3,
      OP_DIV  = 4'd4,  OP_REM  = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7,
      OP_XOR  = 4'd8,  OP_NOT  = 4'd9,  OP_NAND = 4'd10, OP_NOR  = 4'd11,
      OP_XNOR = 4'd12, OP_SHL  = 4'd13, OP_SHR  = 4'd14, OP_CLR  = 4'd15
   } alu_op_e;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      ISSUE = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } drv_state_e;

endpackage

// File: rtl/alu_drv_sat_cnt.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module alu_drv_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // count up on each event until the counter is full
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_op_driver.sv
// Initiator for the 16-channel breadboard ALU. Takes one command at a time,
// drives the ALU pins, waits for the accumulator/carry flop to capture and
// returns the result over a valid/ready response channel.
// Optional feature: define ERR_CNT_EN to build the saturating error counter;
// without it err_count is tied to zero.
module alu_op_driver
   import alu_drv_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int OPW     = OPW_DEF,
   parameter int CNT_W   = 16,
   parameter int DIV_CHK = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [DW-1:0]    cmd_a,
   input  logic [DW-1:0]    cmd_b,
   output logic [DW-1:0]    alu_a,
   output logic [DW-1:0]    alu_b,
   output logic [OPW-1:0]   alu_op,
   output logic             alu_rst,
   input  logic [DW-1:0]    alu_c,
   input  logic             alu_err,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_c,
   output logic             rsp_err,
   output logic             rsp_dz,
   output logic [CNT_W-1:0] err_count
);

   drv_state_e r_state;
   drv_state_e w_next;
   logic       w_accept;
   logic       w_dz;
   logic       w_rsp_hs;

   assign cmd_ready = (r_state == IDLE);
   assign w_accept  = cmd_ready && cmd_valid;
   assign w_rsp_hs  = rsp_valid && rsp_ready;

   // division by zero is answered locally instead of being sent to the ALU
   assign w_dz = (DIV_CHK != 0) &&
                 ((cmd_op == OPW'(OP_DIV)) || (cmd_op == OPW'(OP_REM))) &&
                 (cmd_b == '0);

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= INIT;
      else        r_state <= w_next;
   end

   // next-state: one command in flight, response must be taken before the next accept
   always_comb begin
      w_next = r_state;
      case (r_state)
         INIT:    w_next = IDLE;
         IDLE:    if (cmd_valid) w_next = w_dz ? RESP : ISSUE;
         ISSUE:   w_next = CAPT;
         CAPT:    w_next = RESP;
         RESP:    if (w_rsp_hs) w_next = IDLE;
         default: w_next = INIT;
      endcase
   end

   // ALU pin drive and response capture; rsp_valid rises one cycle into RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= OPW'(OP_CLR);
         alu_rst   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_c     <= '0;
         rsp_err   <= 1'b0;
         rsp_dz    <= 1'b0;
      end else begin
         alu_rst <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_dz) begin
                     rsp_c   <= '0;
                     rsp_err <= 1'b0;
                     rsp_dz  <= 1'b1;
                  end else begin
                     alu_a  <= cmd_a;
                     alu_b  <= cmd_b;
                     alu_op <= cmd_op;
                  end
               end
            end
            // ALU captures on this edge; park it on HOLD so C is retained
            ISSUE: alu_op <= OPW'(OP_HOLD);
            CAPT: begin
               rsp_c   <= alu_c;
               rsp_err <= alu_err;
               rsp_dz  <= 1'b0;
            end
            RESP: begin
               if (!rsp_valid)     rsp_valid <= 1'b1;
               else if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef ERR_CNT_EN
   alu_drv_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_rsp_hs && (rsp_err || rsp_dz)),
      .o_cnt (err_count)
   );
`else
   assign err_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver with a behavioural breadboard ALU and a response
// scoreboard. Honours ERR_CNT_EN for the expected error count.
module tb_alu_op_driver;

   localparam int DW = 32, OPW = 4, CNT_W = 16;

   typedef struct packed {
      logic [DW-1:0] c;
      logic          err;
      logic          dz;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [OPW-1:0]   cmd_op, alu_op;
   logic [DW-1:0]    cmd_a, cmd_b, alu_a, alu_b, alu_c, rsp_c;
   logic             alu_rst, alu_err, rsp_err, rsp_dz;
   logic [CNT_W-1:0] err_count;

   logic [DW-1:0]    m_c;
   logic             m_err;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   alu_op_driver #(.DW(DW), .OPW(OPW), .CNT_W(CNT_W), .DIV_CHK(1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rst(alu_rst),
      .alu_c(alu_c), .alu_err(alu_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_c(rsp_c), .rsp_err(rsp_err), .rsp_dz(rsp_dz),
      .err_count(err_count)
   );

   // breadboard ALU: {carry, C}
   function automatic logic [DW:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, b, c,
                                         input logic e);
      logic [2*DW-1:0] p;
      p = '0;
      case (op)
         4'd0:  return {e, c};
         4'd1:  return {1'b0, a} + {1'b0, b};
         4'd2:  return {1'b0, a} - {1'b0, b};
         4'd3:  begin p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b}; return {|p[2*DW-1:DW], p[DW-1:0]}; end
         4'd4:  return (b == '0) ? '0 : {1'b0, a / b};
         4'd5:  return (b == '0) ? '0 : {1'b0, a % b};
         4'd6:  return {1'b0, a & b};
         4'd7:  return {1'b0, a | b};
         4'd8:  return {1'b0, a ^ b};
         4'd9:  return {1'b0, ~a};
         4'd10: return {1'b0, ~(a & b)};
         4'd11: return {1'b0, ~(a | b)};
         4'd12: return {1'b0, ~(a ^ b)};
         4'd13: return {1'b0, a << b[4:0]};
         4'd14: return {1'b0, a >> b[4:0]};
         default: return '0;
      endcase
   endfunction

   always @(posedge clk) {m_err, m_c} <= alu_rst ? '0 : alu_f(alu_op, alu_a, alu_b, m_c, m_err);
   assign alu_c   = m_c;
   assign alu_err = m_err;

   function automatic exp_t exp_of(input logic [3:0] op, input logic [DW-1:0] a, b);
      exp_t        e;
      logic [DW:0] r;
      if ((op == 4'd4 || op == 4'd5) && b == '0) begin
         e.c = '0; e.err = 1'b0; e.dz = 1'b1;
      end else begin
         r = alu_f(op, a, b, '0, 1'b0);
         e.c = r[DW-1:0]; e.err = r[DW]; e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic int want_cnt();
`ifdef ERR_CNT_EN
      return exp_cnt;
`else
      return 0;
`endif
   endfunction

   // issue one command, check latency, optional backpressure, scoreboard the response
   task automatic run_cmd(input string nm, input logic [3:0] op, input logic [DW-1:0] a, b,
                          input int exp_lat, input int hold, output logic [DW-1:0] got_c);
      int            n, bad_cyc;
      exp_t          e, g;
      logic [DW-1:0] c0;
      got_c = '0;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (cmd_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL %s cmd_ready: got %b want 1", nm, cmd_ready);
         return;
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      sb.push_back(exp_of(op, a, b));
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 4'($urandom_range(0, 15)); cmd_a = $urandom; cmd_b = $urandom;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++;
      if (rsp_valid !== 1'b1 || n != exp_lat) begin
         bad++;
         $display("FAIL %s latency: got %0d (valid=%b) want %0d", nm, n, rsp_valid, exp_lat);
         if (rsp_valid !== 1'b1) begin void'(sb.pop_front()); return; end
      end
      c0 = rsp_c; bad_cyc = 0;
      repeat (hold) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_c !== c0 || cmd_ready !== 1'b0) bad_cyc++;
      end
      if (hold > 0) begin
         total++;
         if (bad_cyc != 0) begin
            bad++;
            $display("FAIL %s hold: unstable cycles got %0d want 0", nm, bad_cyc);
         end
      end
      rsp_ready = 1'b1;
      g.c = rsp_c; g.err = rsp_err; g.dz = rsp_dz;
      @(negedge clk);
      rsp_ready = 1'b0;
      e = sb.pop_front();
      if (e.err || e.dz) exp_cnt++;
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s rsp: got c=%h err=%b dz=%b want c=%h err=%b dz=%b",
                  nm, g.c, g.err, g.dz, e.c, e.err, e.dz);
      end
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s rsp_drop: got %b want 0", nm, rsp_valid);
      end
      got_c = g.c;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (alu_rst !== 1'b1 || alu_op !== 4'hF || alu_a !== '0 || alu_b !== '0) begin
         bad++;
         $display("FAIL reset_pins: got rst=%b op=%h a=%h b=%h want 1 f 0 0", alu_rst, alu_op, alu_a, alu_b);
      end
      total++;
      if ({rsp_valid, rsp_err, rsp_dz, cmd_ready} !== 4'b0 || rsp_c !== '0 || err_count !== '0) begin
         bad++;
         $display("FAIL reset_rsp: got v=%b c=%h e=%b dz=%b rdy=%b cnt=%0d want all 0",
                  rsp_valid, rsp_c, rsp_err, rsp_dz, cmd_ready, err_count);
      end
      reset = 1'b1;
      #1;
      total++;
      if (alu_rst !== 1'b1 || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL init_cycle: got rst=%b rdy=%b want 1 0", alu_rst, cmd_ready);
      end
      @(negedge clk);
      total++;
      if (alu_rst !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL idle_after_init: got rst=%b rdy=%b want 0 1", alu_rst, cmd_ready);
      end
   endtask

   task automatic test_add();
      logic [DW-1:0] c;
      run_cmd("add", 4'd1, 32'd5, 32'd7, 3, 0, c);
      total++;
      if (c !== 32'd12) begin bad++; $display("FAIL add_value: got %0d want 12", c); end
      total++;
      if (alu_op !== 4'd0) begin bad++; $display("FAIL add_hold_op: got %h want 0", alu_op); end
   endtask

   task automatic test_carry();
      logic [DW-1:0] c;
      run_cmd("add_carry", 4'd1, 32'hFFFF_FFFF, 32'd1, 3, 0, c);
      total++;
      if (c !== '0) begin bad++; $display("FAIL carry_value: got %h want 0", c); end
      total++;
      if (err_count !== CNT_W'(want_cnt())) begin
         bad++; $display("FAIL carry_cnt: got %0d want %0d", err_count, want_cnt());
      end
   endtask

   task automatic test_div0();
      logic [DW-1:0] c;
      run_cmd("div0", 4'd4, 32'd10, 32'd0, 1, 0, c);
      total++;
      if (alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd1 || alu_op !== 4'd0) begin
         bad++;
         $display("FAIL div0_pins: got a=%h b=%h op=%h want ffffffff 1 0", alu_a, alu_b, alu_op);
      end
      total++;
      if (err_count !== CNT_W'(want_cnt())) begin
         bad++; $display("FAIL div0_cnt: got %0d want %0d", err_count, want_cnt());
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] c;
      run_cmd("shl_bp", 4'd13, 32'h8000_0001, 32'd1, 3, 5, c);
      total++;
      if (c !== 32'h0000_0002) begin bad++; $display("FAIL shl_value: got %h want 00000002", c); end
   endtask

   task automatic test_ops();
      logic [3:0]    ops [0:11] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd5};
      logic [DW-1:0] c, a, b;
      run_cmd("sub_borrow", 4'd2, 32'd3, 32'd5, 3, 0, c);
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = (i == 11) ? '0 : ((ops[i] == 4'd3) ? 32'($urandom_range(0, 70000)) : $urandom);
         run_cmd($sformatf("op%0d", ops[i]), ops[i], a, b,
                 ((ops[i] == 4'd4 || ops[i] == 4'd5) && b == '0) ? 1 : 3, i % 3, c);
      end
      total++;
      if (err_count !== CNT_W'(want_cnt())) begin
         bad++; $display("FAIL ops_cnt: got %0d want %0d", err_count, want_cnt());
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] c;
      int            n, bad_cyc;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_op = 4'd3; cmd_a = 32'd3; cmd_b = 32'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || alu_rst !== 1'b1 || cmd_ready !== 1'b0 || err_count !== '0) begin
         bad++;
         $display("FAIL mid_reset: got v=%b rst=%b rdy=%b cnt=%0d want 0 1 0 0",
                  rsp_valid, alu_rst, cmd_ready, err_count);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_cnt = 0;
      #1;
      total++;
      if (cmd_ready !== 1'b0 || alu_rst !== 1'b1) begin
         bad++; $display("FAIL mid_init: got rdy=%b rst=%b want 0 1", cmd_ready, alu_rst);
      end
      bad_cyc = 0;
      repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) bad_cyc++; end
      total++;
      if (bad_cyc != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d valid cycles want 0", bad_cyc); end
      run_cmd("add_after_reset", 4'd1, 32'd1, 32'd1, 3, 0, c);
      total++;
      if (c !== 32'd2) begin bad++; $display("FAIL after_reset_value: got %0d want 2", c); end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      #1 reset = 1'b0;
      test_reset();
      test_add();
      test_carry();
      test_div0();
      test_backpressure();
      test_ops();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
